teclado_escaner: RTL and testbench
==================================

// Module: teclado_escaner
// PURPOSE
//  Scans a 4x4 matrix keypad and produces the digit and operator events that
//  feed the calculator's number-entry FSM. It drives one column low at a time,
//  synchronises and debounces the row lines, and encodes the pressed key to a
//  4-bit code. Each press gives exactly one 1-cycle pulse: numero_en or operacion_en.
// PARAMETERS
//  SCAN_DIV         16     clk cycles each column is driven before rows are sampled (>=3)
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required for press and for release (>=2)
//  REPEAT_CYCLES    5000000 auto-repeat period; used only with TECLADO_AUTOREPEAT_EN
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous reset, active-high
//  filas         in   4  keypad rows, active-low, asynchronous (external pull-ups)
//  columnas      out  4  keypad columns, active-low, exactly one bit low at all times
//  nuevo_numero  out  4  code of last accepted key; held until the next accepted key
//  numero_en     out  1  1-cycle pulse: accepted key is a digit (code 0..9)
//  operacion_en  out  1  1-cycle pulse: accepted key is A,B,C,D,*,# (code A..F)
// BEHAVIOUR
//  Reset (sync): state=SCAN, col=0, columnas=4'b1110, nuevo_numero=0, pulses=0, counters=0.
//  Key map [row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: *=E 0=0 #=F D.
//  filas always pass through a 2-FF synchroniser, so there are 2 cycles of input latency.
//  States:
//   SCAN: drive col low and count 0..SCAN_DIV-1. At the last count, sample filas_s.
//     If any bit is low, latch the lowest-index low row plus col, clear the counter,
//     and go to DEBOUNCE. Otherwise advance col (3 wraps to 0) and restart the count.
//   DEBOUNCE: keep col driven. Each cycle filas_s equals the latched pattern, cnt++.
//     Any mismatch: return to SCAN and advance col; no output.
//     When cnt==DEBOUNCE_CYCLES-1: go to EMIT.
//   EMIT (exactly 1 cycle): nuevo_numero<=code. Assert numero_en if code<=9,
//     else operacion_en. The pulses never assert together. Go to RELEASE with cnt=0.
//   RELEASE: keep col driven. cnt++ while filas_s==4'b1111; any low bit resets cnt to 0.
//     When cnt==DEBOUNCE_CYCLES-1: go to SCAN with the same col.
//  Press-to-pulse latency: 2 sync cycles + remaining scan time + DEBOUNCE_CYCLES + 1 cycle.
//  Multiple keys in one column: the lowest row wins.
//  Keys in other columns pressed while one is held: ignored. At most one pulse per press.
//  Reset mid-debounce or mid-release: no pulse that cycle; scanning restarts at col 0.
//   A key still held after reset is re-detected and emitted once.
//  Counters are sized with $clog2 of the largest parameter and never wrap in normal use.
// CONFIGURATION
//  TECLADO_AUTOREPEAT_EN defined:
//   - In RELEASE, while the key stays pressed, a repeat counter runs.
//   - Every REPEAT_CYCLES it re-emits the same code with a 1-cycle pulse of the same type.
//   - The counter clears on release.
//  Undefined: repeat logic absent; strictly one pulse per press.
// STRUCTURE
//  teclado_defs.vh: state encodings (SCAN, DEBOUNCE, EMIT, RELEASE), key code
//   localparams (TECLA_A..TECLA_NUMERAL), 16-entry row/col -> code ROM function.
//  Sub-module sincronizador_2ff (parameter WIDTH=4), reused for other async inputs.
//  Scan FSM, counters, encoder and output registers live in teclado_escaner.
// TESTING (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=40; keypad model)
//  1 Hold key '5' (r1,c1) for 40 cycles -> one numero_en pulse, nuevo_numero=4'h5,
//    operacion_en stays 0, columnas frozen at 4'b1101 until release completes.
//  2 Press '#' (r3,c2) -> one operacion_en pulse, nuevo_numero=4'hF.
//  3 Press '7' with 3-cycle bounce glitches during the first 6 cycles -> exactly one
//    pulse after stability. A 5-cycle tap -> no pulse.
//  4 Hold '1' and '4' together (same c0) -> code 4'h1 only.
//    Then press '9' while '1' is held -> ignored.
//  5 Assert reset during DEBOUNCE of '0' -> no pulse, columnas=4'b1110 next cycle.
//    Key still held -> one pulse with code 4'h0 after re-detect.
//  6 With TECLADO_AUTOREPEAT_EN, hold '3' for 130 cycles after first pulse -> 3 repeat
//    pulses 40 cycles apart. Without the macro -> 1 pulse total.

Source files
------------

// File: rtl/teclado_escaner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// key-code constants, the row/column -> key-code map and small helpers.
package teclado_escaner_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    localparam logic [3:0] TECLA_A         = 4'hA;
    localparam logic [3:0] TECLA_B         = 4'hB;
    localparam logic [3:0] TECLA_C         = 4'hC;
    localparam logic [3:0] TECLA_D         = 4'hD;
    localparam logic [3:0] TECLA_ASTERISCO = 4'hE;
    localparam logic [3:0] TECLA_NUMERAL   = 4'hF;

    // Row lines idle high through the external pull-ups.
    localparam logic [3:0] FILAS_REPOSO = 4'b1111;

    // Keypad layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        case ({fila, col})
            4'h0:    codigo = 4'h1;
            4'h1:    codigo = 4'h2;
            4'h2:    codigo = 4'h3;
            4'h3:    codigo = TECLA_A;
            4'h4:    codigo = 4'h4;
            4'h5:    codigo = 4'h5;
            4'h6:    codigo = 4'h6;
            4'h7:    codigo = TECLA_B;
            4'h8:    codigo = 4'h7;
            4'h9:    codigo = 4'h8;
            4'hA:    codigo = 4'h9;
            4'hB:    codigo = TECLA_C;
            4'hC:    codigo = TECLA_ASTERISCO;
            4'hD:    codigo = 4'h0;
            4'hE:    codigo = TECLA_NUMERAL;
            default: codigo = TECLA_D;
        endcase
        return codigo;
    endfunction

    // Index of the lowest active-low row; several keys in one column resolve to the lowest row.
    function automatic logic [1:0] fila_mas_baja(input logic [3:0] filas);
        logic [1:0] fila;
        fila = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!filas[i]) fila = 2'(i);
        end
        return fila;
    endfunction

    // Active-low one-cold column drive pattern.
    function automatic logic [3:0] columna_activa(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/teclado_escaner_if.sv
// Keypad scanner bus: keypad row/column lines plus the key-event outputs
// consumed by the calculator's number-entry FSM.
interface teclado_escaner_if;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] nuevo_numero;
    logic       numero_en;
    logic       operacion_en;

    // Scanner side: reads rows, drives columns and key events.
    modport master (
        input  filas,
        output columnas,
        output nuevo_numero,
        output numero_en,
        output operacion_en
    );

    // Keypad / consumer side.
    modport slave (
        output filas,
        input  columnas,
        input  nuevo_numero,
        input  numero_en,
        input  operacion_en
    );
endinterface

// File: rtl/teclado_escaner_sincronizador.sv
// Two-flop synchroniser for asynchronous inputs; no reset, it only carries data
// and flushes itself within two clocks.
module sincronizador_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    // Two register stages to let metastability settle.
    always_ff @(posedge clk) begin
        sync_p0 <= d;
        sync_p1 <= sync_p0;
    end

    assign q = sync_p1;
endmodule

// File: rtl/teclado_escaner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces the
// synchronised rows on press and on release, and emits one 1-cycle pulse per
// accepted key (numero_en for 0..9, operacion_en for A..F).
// Optional feature macro: TECLADO_AUTOREPEAT_EN re-emits a held key every
// REPEAT_CYCLES clocks while it stays pressed.
module teclado_escaner
    import teclado_escaner_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    teclado_escaner_if.master  bus
);
    localparam int CNT_MAX_A = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_CYCLES) ? CNT_MAX_A : REPEAT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SCAN_FIN = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_FIN  = CNT_W'(DEBOUNCE_CYCLES - 1);

    estado_t          estado, estado_n;
    logic [1:0]       col, col_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       filas_s;
    logic [3:0]       patron;
    logic [1:0]       fila_lat;
    logic             captura;
    logic             emitir;
    logic             disparo;
    logic [3:0]       codigo;
    logic             es_digito;
    logic [3:0]       nuevo_numero_r;
    logic             numero_en_r;
    logic             operacion_en_r;

    sincronizador_2ff #(.WIDTH(4)) u_sync_filas (
        .clk (clk),
        .d   (bus.filas),
        .q   (filas_s)
    );

    assign codigo    = codigo_tecla(fila_lat, col);
    assign es_digito = (codigo <= 4'd9);

    // Scan/debounce/emit/release sequencing and counter control.
    always_comb begin
        estado_n = estado;
        col_n    = col;
        cnt_n    = cnt;
        captura  = 1'b0;
        emitir   = 1'b0;
        case (estado)
            SCAN: begin
                if (cnt == SCAN_FIN) begin
                    cnt_n = '0;
                    if (filas_s != FILAS_REPOSO) begin
                        captura  = 1'b1;
                        estado_n = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (filas_s != patron) begin
                    estado_n = SCAN;
                    col_n    = col + 2'd1;
                    cnt_n    = '0;
                end else if (cnt == DEB_FIN) begin
                    estado_n = EMIT;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EMIT: begin
                emitir   = 1'b1;
                estado_n = RELEASE;
                cnt_n    = '0;
            end
            RELEASE: begin
                if (filas_s != FILAS_REPOSO) begin
                    cnt_n = '0;
                end else if (cnt == DEB_FIN) begin
                    estado_n = SCAN;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                estado_n = SCAN;
                cnt_n    = '0;
            end
        endcase
    end

`ifdef TECLADO_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_FIN = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
    logic             rep_disparo;

    // Repeat timer: runs only while the accepted key is still held, clears otherwise.
    always_comb begin
        rep_cnt_n   = '0;
        rep_disparo = 1'b0;
        if (estado == RELEASE && filas_s != FILAS_REPOSO) begin
            if (rep_cnt == REP_FIN) begin
                rep_disparo = 1'b1;
            end else begin
                rep_cnt_n = rep_cnt + 1'b1;
            end
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk) begin
        if (reset) rep_cnt <= '0;
        else       rep_cnt <= rep_cnt_n;
    end

    assign disparo = emitir | rep_disparo;
`else
    assign disparo = emitir;
`endif

    // State, column, counter and key-event output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= SCAN;
            col            <= 2'd0;
            cnt            <= '0;
            nuevo_numero_r <= 4'd0;
            numero_en_r    <= 1'b0;
            operacion_en_r <= 1'b0;
        end else begin
            estado         <= estado_n;
            col            <= col_n;
            cnt            <= cnt_n;
            numero_en_r    <= disparo & es_digito;
            operacion_en_r <= disparo & ~es_digito;
            if (disparo) nuevo_numero_r <= codigo;
        end
    end

    // Capture the row pattern and winning row when a candidate press is found.
    always_ff @(posedge clk) begin
        if (captura) begin
            patron   <= filas_s;
            fila_lat <= fila_mas_baja(filas_s);
        end
    end

    assign bus.columnas     = columna_activa(col);
    assign bus.nuevo_numero = nuevo_numero_r;
    assign bus.numero_en    = numero_en_r;
    assign bus.operacion_en = operacion_en_r;
endmodule

// File: tb/tb_teclado_escaner.sv
// Bench for teclado_escaner: keypad model, expected-key scoreboard checked
// every cycle, and directed scenarios with hand-computed timing points.
`timescale 1ns/1ps
module tb_teclado_escaner;
    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int REPEAT_CYCLES   = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    teclado_escaner_if bus();

    teclado_escaner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Keypad model: pressed[r][c]; a row reads low when a pressed key sits on a driven column.
    logic [3:0] pressed [4];
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            bus.filas[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !bus.columnas[c]) bus.filas[r] = 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int n_pulses = 0;
    logic [3:0] exp_q [$];
    logic [3:0] last_code = 4'd0;
    logic rst_at_edge = 1'b0;
    bit armed = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    endtask

    // Reset as seen by the DUT at each active edge.
    initial begin
        forever begin
            @(posedge clk);
            rst_at_edge = reset;
        end
    end

    // Per-cycle comparison against the model: one driven column, exclusive pulses,
    // pulses match the expected key queue, nuevo_numero holds the last accepted key.
    initial begin
        logic [3:0] code;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                armed     = 1'b1;
                last_code = 4'd0;
                check("reset_columnas", bus.columnas, 4'b1110);
                check("reset_nuevo_numero", bus.nuevo_numero, 0);
                check("reset_pulses", {bus.numero_en, bus.operacion_en}, 0);
            end else if (armed) begin
                check("one_column_low", $countones(~bus.columnas), 1);
                check("pulses_exclusive", int'(bus.numero_en && bus.operacion_en), 0);
                if (bus.numero_en || bus.operacion_en) begin
                    n_pulses++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse_code", bus.nuevo_numero, 16);
                    end else begin
                        code      = exp_q.pop_front();
                        last_code = code;
                        check("pulse_type_digit", bus.numero_en, int'(code <= 4'd9));
                    end
                end
                check("nuevo_numero_model", bus.nuevo_numero, last_code);
            end
        end
    end

    initial begin
        int base;
        bit got;
        logic [5:0] bounce;
        release_all();

        // Reset state.
        reset = 1'b1;
        tick(4);
        check("t0_columnas", bus.columnas, 4'b1110);
        check("t0_nuevo", bus.nuevo_numero, 0);
        check("t0_numero_en", bus.numero_en, 0);
        check("t0_operacion_en", bus.operacion_en, 0);

        // Test 1: '5' at r1,c1, pressed as reset releases; pulse after edge 17.
        reset = 1'b0;
        pressed[1][1] = 1'b1;
        exp_q.push_back(4'h5);
        base = n_pulses;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 16) check("t1_no_pulse_yet", bus.numero_en, 0);
            if (i == 17) begin
                check("t1_pulse", bus.numero_en, 1);
                check("t1_code", bus.nuevo_numero, 4'h5);
            end
            if (i == 18) check("t1_pulse_one_cycle", bus.numero_en, 0);
            if (i == 17 || i == 30 || i == 53) check("t1_col_frozen", bus.columnas, 4'b1101);
            if (i == 54) check("t1_scan_resumes", bus.columnas, 4'b1011);
            if (i == 40) pressed[1][1] = 1'b0;
        end
        check("t1_pulse_count", n_pulses - base, 1);
        check("t1_operacion_idle", bus.operacion_en, 0);

        // Test 2: '#' at r3,c2.
        exp_q.push_back(4'hF);
        base = n_pulses;
        pressed[3][2] = 1'b1;
        tick(50);
        pressed[3][2] = 1'b0;
        tick(30);
        check("t2_pulse_count", n_pulses - base, 1);
        check("t2_code", bus.nuevo_numero, 4'hF);

        // Test 3a: '7' (r2,c0) with a 3-cycle release glitch in the first 6 cycles.
        exp_q.push_back(4'h7);
        base = n_pulses;
        bounce = 6'b100011;
        for (int k = 0; k < 6; k++) begin
            pressed[2][0] = bounce[k];
            tick(1);
        end
        pressed[2][0] = 1'b1;
        tick(50);
        pressed[2][0] = 1'b0;
        tick(30);
        check("t3_bounce_pulse_count", n_pulses - base, 1);
        check("t3_code", bus.nuevo_numero, 4'h7);

        // Test 3b: 5-cycle tap of '8' is too short to be accepted.
        base = n_pulses;
        pressed[2][1] = 1'b1;
        tick(5);
        pressed[2][1] = 1'b0;
        tick(40);
        check("t3_tap_no_pulse", n_pulses - base, 0);

        // Test 4: '1' and '4' in column 0 -> '1'; then '9' pressed while held is ignored.
        exp_q.push_back(4'h1);
        base = n_pulses;
        pressed[0][0] = 1'b1;
        pressed[1][0] = 1'b1;
        tick(50);
        pressed[2][2] = 1'b1;
        tick(20);
        release_all();
        tick(40);
        check("t4_pulse_count", n_pulses - base, 1);
        check("t4_code", bus.nuevo_numero, 4'h1);

        // Test 5: reset during debounce of '0' (r3,c1), key held -> one pulse after re-detect.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        pressed[3][1] = 1'b1;
        exp_q.push_back(4'h0);
        base = n_pulses;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (i == 11) reset = 1'b1;
            if (i == 12) begin
                check("t5_reset_columnas", bus.columnas, 4'b1110);
                check("t5_reset_no_pulse", bus.numero_en, 0);
                reset = 1'b0;
            end
            if (i == 28) check("t5_no_pulse_yet", bus.numero_en, 0);
            if (i == 29) begin
                check("t5_redetect_pulse", bus.numero_en, 1);
                check("t5_code", bus.nuevo_numero, 4'h0);
            end
        end
        pressed[3][1] = 1'b0;
        tick(30);
        check("t5_pulse_count", n_pulses - base, 1);

        // Test 6: hold '3' (r0,c2) for 130 cycles after its first pulse.
        exp_q.push_back(4'h3);
`ifdef TECLADO_AUTOREPEAT_EN
        for (int k = 0; k < 3; k++) exp_q.push_back(4'h3);
`endif
        base = n_pulses;
        got = 1'b0;
        pressed[0][2] = 1'b1;
        for (int k = 0; k < 60 && !got; k++) begin
            tick(1);
            if (bus.numero_en) got = 1'b1;
        end
        check("t6_first_pulse_seen", int'(got), 1);
        tick(130);
        pressed[0][2] = 1'b0;
        tick(40);
`ifdef TECLADO_AUTOREPEAT_EN
        check("t6_pulse_count", n_pulses - base, 4);
`else
        check("t6_pulse_count", n_pulses - base, 1);
`endif
        check("t6_code", bus.nuevo_numero, 4'h3);

        tick(5);
        check("all_expected_keys_seen", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
